// File: rtl/core_pkg.sv
// core_pkg: hazard optype encodings and forwarding-source constants shared by
// the decode control unit and the hazard scoreboard.
package core_pkg;
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } optype_e;

    localparam int FWD_SRC_RF = 0;

    function automatic logic writes_rf(input logic [1:0] op);
        return op == OP_ALU || op == OP_LOAD;
    endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow pipeline slot (valid/rd/optype) with enable
// and asynchronous clear.
module hazard_stage_reg import core_pkg::*; #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [1:0]        op_i,
    output logic              valid_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [1:0]        op_o
);
    logic              valid_q;
    logic [REG_AW-1:0] rd_q;
    logic [1:0]        op_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            op_q    <= OP_NONE;
        end else if (en_i) begin
            valid_q <= valid_i;
            rd_q    <= rd_i;
            op_q    <= op_i;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign op_o    = op_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RV32I load-use stall, IF/ID flush and operand forwarding
// control, driven by a shadow copy of the stages downstream of ID.
module hazard_scoreboard import core_pkg::*; #(
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int REG_AW     = 5,
    parameter int FWD_W      = $clog2(NUM_STAGES + 1),
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1use,
    input  logic              id_rs2use,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_optype,
    input  logic              id_branch,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic [NUM_STAGES:1] st_valid, in_valid, m_a, m_b;
    logic [REG_AW-1:0]   st_rd [1:NUM_STAGES];
    logic [REG_AW-1:0]   in_rd [1:NUM_STAGES];
    logic [1:0]          st_op [1:NUM_STAGES];
    logic [1:0]          in_op [1:NUM_STAGES];
    logic                lu;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
        if (k == 1) begin : g_head
            assign in_valid[k] = id_valid & ~lu;
            assign in_rd[k]    = id_rd;
            assign in_op[k]    = id_optype;
        end else begin : g_tail
            assign in_valid[k] = st_valid[k-1];
            assign in_rd[k]    = st_rd[k-1];
            assign in_op[k]    = st_op[k-1];
        end
        // A slot produces a register value only for ALU/LOAD ops targeting a non-x0 rd
        assign m_a[k] = id_valid && id_rs1use && st_valid[k] && writes_rf(st_op[k])
                        && st_rd[k] != '0 && st_rd[k] == id_rs1;
        assign m_b[k] = id_valid && id_rs2use && st_valid[k] && writes_rf(st_op[k])
                        && st_rd[k] != '0 && st_rd[k] == id_rs2;
        hazard_stage_reg #(.REG_AW(REG_AW)) u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .en_i    (~ext_stall),
            .valid_i (in_valid[k]),
            .rd_i    (in_rd[k]),
            .op_i    (in_op[k]),
            .valid_o (st_valid[k]),
            .rd_o    (st_rd[k]),
            .op_o    (st_op[k])
        );
    end

    // Scan far-to-near so the nearest producer overwrites the select last
    always_comb begin
        fwd_a = FWD_W'(FWD_SRC_RF);
        fwd_b = FWD_W'(FWD_SRC_RF);
        lu    = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (m_a[k]) fwd_a = FWD_W'(k);
            if (m_b[k]) fwd_b = FWD_W'(k);
            if ((m_a[k] || m_b[k]) && st_op[k] == OP_LOAD && k < 1 + LOAD_LAT) lu = 1'b1;
        end
    end

    assign stall_pc    = ext_stall | lu;
    assign stall_ifid  = ext_stall | lu;
    assign bubble_idex = ~ext_stall & lu;
    assign flush_ifid  = ~ext_stall & ~lu & id_branch & id_valid;

    assign cnt_d = (!ext_stall && lu && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three parameterisations of hazard_scoreboard driven in
// lockstep, checked every cycle against a queue-style reference model.
module tb_hazard_scoreboard;
    import core_pkg::*;
    localparam int N = 3;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [1:0] op;
    } ent_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ext_stall = 1'b0, id_valid = 1'b0, id_rs1use = 1'b0, id_rs2use = 1'b0, id_branch = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [1:0] id_optype = '0;

    logic sp [N], si [N], fl [N], bb [N];
    logic [1:0] fa0, fb0, fa2, fb2;
    logic [2:0] fa1, fb1;
    logic [31:0] c0, c1;
    logic [3:0] c2;
    longint fa [N], fb [N], cn [N];

    ent_t   pipe [N][1:6];
    longint mcnt [N];
    int     ns [N] = '{3, 4, 3};
    int     ll [N] = '{1, 2, 1};
    int     cw [N] = '{32, 32, 4};
    int     vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_d0 (
        .clk(clk), .rstn(rstn), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1use(id_rs1use), .id_rs2use(id_rs2use),
        .id_rd(id_rd), .id_optype(id_optype), .id_branch(id_branch),
        .stall_pc(sp[0]), .stall_ifid(si[0]), .flush_ifid(fl[0]), .bubble_idex(bb[0]),
        .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(c0)
    );
    hazard_scoreboard #(.NUM_STAGES(4), .LOAD_LAT(2)) u_d1 (
        .clk(clk), .rstn(rstn), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1use(id_rs1use), .id_rs2use(id_rs2use),
        .id_rd(id_rd), .id_optype(id_optype), .id_branch(id_branch),
        .stall_pc(sp[1]), .stall_ifid(si[1]), .flush_ifid(fl[1]), .bubble_idex(bb[1]),
        .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(c1)
    );
    hazard_scoreboard #(.CNT_W(4)) u_d2 (
        .clk(clk), .rstn(rstn), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1use(id_rs1use), .id_rs2use(id_rs2use),
        .id_rd(id_rd), .id_optype(id_optype), .id_branch(id_branch),
        .stall_pc(sp[2]), .stall_ifid(si[2]), .flush_ifid(fl[2]), .bubble_idex(bb[2]),
        .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(c2)
    );

    always_comb begin
        fa[0] = 64'(fa0); fa[1] = 64'(fa1); fa[2] = 64'(fa2);
        fb[0] = 64'(fb0); fb[1] = 64'(fb1); fb[2] = 64'(fb2);
        cn[0] = 64'(c0);  cn[1] = 64'(c1);  cn[2] = 64'(c2);
    end

    function automatic bit producer(int i, int k, logic [4:0] rs, logic en);
        return id_valid && en && pipe[i][k].v && (pipe[i][k].op == OP_ALU || pipe[i][k].op == OP_LOAD)
               && pipe[i][k].rd != 0 && pipe[i][k].rd == rs;
    endfunction

    function automatic int nearest(int i, logic [4:0] rs, logic en);
        for (int k = 1; k <= ns[i]; k++)
            if (producer(i, k, rs, en)) return k;
        return 0;
    endfunction

    function automatic bit hazard(int i);
        for (int k = 1; k < 1 + ll[i]; k++)
            if (pipe[i][k].op == OP_LOAD && (producer(i, k, id_rs1, id_rs1use) || producer(i, k, id_rs2, id_rs2use)))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string nm, input int i, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Reference model: shift the shadow queue and count stalls from the rules
    always @(posedge clk or negedge rstn) begin
        bit h;
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 1; k <= 6; k++) pipe[i][k] = '0;
                mcnt[i] = 0;
            end
        end else if (!ext_stall) begin
            for (int i = 0; i < N; i++) begin
                h = hazard(i);
                for (int k = ns[i]; k >= 2; k--) pipe[i][k] = pipe[i][k-1];
                pipe[i][1] = {id_valid & ~h, id_rd, id_optype};
                if (h && mcnt[i] < (longint'(1) << cw[i]) - 1) mcnt[i]++;
            end
        end
    end

    always @(negedge clk) begin
        bit h;
        for (int i = 0; i < N; i++) begin
            h = hazard(i);
            check("stall_pc", i, sp[i], ext_stall | h);
            check("stall_ifid", i, si[i], ext_stall | h);
            check("bubble_idex", i, bb[i], !ext_stall && h);
            check("flush_ifid", i, fl[i], !ext_stall && !h && id_branch && id_valid);
            check("fwd_a", i, fa[i], nearest(i, id_rs1, id_rs1use));
            check("fwd_b", i, fb[i], nearest(i, id_rs2, id_rs2use));
            check("stall_cnt", i, cn[i], mcnt[i]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] rd, input logic [1:0] op,
                         input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2, input bit br);
        step();
        id_valid = v; id_rd = rd; id_optype = op;
        id_rs1 = r1; id_rs1use = u1; id_rs2 = r2; id_rs2use = u2; id_branch = br;
    endtask

    task automatic drain();
        repeat (5) drive(0, 0, OP_NONE, 0, 0, 0, 0, 0);
    endtask

    initial begin
        id_valid = 1'b1; id_rs1use = 1'b1; id_rs1 = 5'd5;
        repeat (3) @(posedge clk);
        #3;
        check("rst_stall_pc", 0, sp[0], 0);
        check("rst_bubble", 0, bb[0], 0);
        check("rst_flush", 0, fl[0], 0);
        check("rst_fwd_a", 0, fa[0], 0);
        check("rst_cnt", 0, cn[0], 0);
        step();
        rstn = 1'b1;
        #2 check("post_rst_fwd_a", 0, fa[0], 0);
        drain();

        drive(1, 5, OP_ALU, 0, 0, 0, 0, 0);
        drive(1, 6, OP_ALU, 5, 1, 0, 0, 0);
        #2 check("alu_fwd1", 0, fa[0], 1);
        check("alu_nostall", 0, sp[0], 0);
        step(); #2 check("alu_fwd2", 0, fa[0], 2);
        step(); #2 check("alu_fwd3", 0, fa[0], 3);
        step(); #2 check("alu_fwd0", 0, fa[0], 0);
        check("alu_fwd4_ns4", 1, fa[1], 4);
        drain();

        drive(1, 7, OP_LOAD, 0, 0, 0, 0, 0);
        drive(1, 8, OP_ALU, 7, 1, 7, 1, 0);
        #2 check("lu_stall_pc", 0, sp[0], 1);
        check("lu_stall_ifid", 0, si[0], 1);
        check("lu_bubble", 0, bb[0], 1);
        step(); #2 check("lu_done", 0, sp[0], 0);
        check("lu_fwd_a", 0, fa[0], 2);
        check("lu_fwd_b", 0, fb[0], 2);
        check("lu_cnt", 0, cn[0], 1);
        check("lu2_stall2", 1, sp[1], 1);
        step(); #2 check("lu2_done", 1, sp[1], 0);
        check("lu2_fwd_a", 1, fa[1], 3);
        check("lu2_cnt", 1, cn[1], 2);
        drain();

        drive(1, 7, OP_LOAD, 0, 0, 0, 0, 0);
        drive(1, 9, OP_ALU, 0, 0, 0, 0, 0);
        drive(1, 8, OP_ALU, 7, 1, 0, 0, 0);
        #2 check("gap_stall", 1, bb[1], 1);
        check("gap_d0_fwd", 0, fa[0], 2);
        step(); #2 check("gap_done", 1, sp[1], 0);
        check("gap_fwd", 1, fa[1], 3);
        drain();

        drive(1, 7, OP_LOAD, 0, 0, 0, 0, 0);
        drive(1, 8, OP_ALU, 7, 1, 0, 0, 1);
        ext_stall = 1'b1;
        #2 check("ext_stall_pc", 0, sp[0], 1);
        check("ext_no_bubble", 0, bb[0], 0);
        check("ext_no_flush", 0, fl[0], 0);
        step(); #2 check("ext_frozen_fwd", 0, fa[0], 1);
        check("ext_cnt_hold", 0, cn[0], 1);
        step();
        ext_stall = 1'b0;
        #2 check("br_lu_bubble", 0, bb[0], 1);
        check("br_lu_noflush", 0, fl[0], 0);
        step(); #2 check("br_flush", 0, fl[0], 1);
        check("br_fwd", 0, fa[0], 2);
        check("br_cnt", 0, cn[0], 2);
        drive(0, 0, OP_NONE, 0, 0, 0, 0, 0);
        #2 check("br_flush_once", 0, fl[0], 0);
        drain();

        drive(1, 0, OP_ALU, 0, 0, 0, 0, 0);
        drive(1, 8, OP_ALU, 0, 1, 0, 1, 0);
        #2 check("x0_fwd_a", 0, fa[0], 0);
        drive(1, 5, OP_STORE, 0, 0, 0, 0, 0);
        drive(1, 8, OP_ALU, 5, 1, 0, 0, 0);
        #2 check("store_nomatch", 0, fa[0], 0);
        drive(1, 3, OP_ALU, 0, 0, 0, 0, 0);
        drive(1, 4, OP_ALU, 0, 0, 0, 0, 0);
        drive(1, 8, OP_ALU, 3, 1, 4, 1, 0);
        #2 check("indep_a", 0, fa[0], 2);
        check("indep_b", 0, fb[0], 1);
        drive(1, 3, OP_ALU, 0, 0, 0, 0, 0);
        drive(1, 9, OP_ALU, 3, 1, 0, 0, 0);
        #2 check("nearest", 0, fa[0], 1);
        drive(0, 8, OP_ALU, 3, 1, 3, 1, 1);
        #2 check("novalid_fwd", 0, fa[0], 0);
        check("novalid_flush", 0, fl[0], 0);
        drain();

        repeat (20) begin
            drive(1, 7, OP_LOAD, 0, 0, 0, 0, 0);
            drive(1, 8, OP_ALU, 7, 1, 0, 0, 0);
            step();
        end
        drive(0, 0, OP_NONE, 0, 0, 0, 0, 0);
        #2 check("sat_cnt4", 2, cn[2], 15);
        check("cnt32", 0, cn[0], 22);

        for (int c = 0; c < 3000; c++) begin
            step();
            rstn = 1'b1;
            ext_stall = $urandom_range(0, 4) == 0;
            id_valid = $urandom_range(0, 5) != 0;
            id_rd = 5'($urandom_range(0, 3));
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_rs1use = 1'($urandom_range(0, 1));
            id_rs2use = 1'($urandom_range(0, 1));
            id_optype = 2'($urandom_range(0, 3));
            id_branch = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 199) == 0) begin
                #2 rstn = 1'b0;
            end
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
